sequence_player: RTL

//  Consumes the (addr, color, write) stream from the level loader into an internal DEPTH x 2-bit

---
 rtl/sequence_player.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Colour store plus timed LED playback of the first `level` stored colours.
// Optional build macro SEQ_PLAYER_PAUSE_EN adds a `pause` input that freezes playback.
module sequence_player #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int ON_TICKS  = 25_000_000,
    parameter int OFF_TICKS = 12_500_000,
    parameter int CNT_W     = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_color,
    input  logic              start,
    input  logic [3:0]        level,
`ifdef SEQ_PLAYER_PAUSE_EN
    input  logic              pause,
`endif
    output logic              busy,
    output logic              led_on,
    output logic [1:0]        led_color,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

    logic [1:0]        mem [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] next_idx;
    logic [ADDR_W-1:0] start_last;
    logic [CNT_W-1:0]  cnt;
    logic              hold;

`ifdef SEQ_PLAYER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign next_idx = idx + ADDR_W'(1);

    // Index of the final colour; level above DEPTH clamps to the last slot.
    always_comb begin
        start_last = ADDR_W'(DEPTH - 1);
        if (int'(level) < DEPTH) begin
            start_last = ADDR_W'(level) - ADDR_W'(1);
        end
    end

    // NOTE: the store is cleared on reset, so a replay after reset shows colour 0 everywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'd0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_color;
        end
    end

    // NOTE: state and outputs use <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            last_idx  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            led_on    <= 1'b0;
            led_color <= 2'd0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (level == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ON;
                            idx       <= '0;
                            last_idx  <= start_last;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            led_on    <= 1'b1;
                            led_color <= mem[0];
                        end
                    end
                end
                S_ON: begin
                    if (!hold) begin
                        if (cnt == ON_LAST) begin
                            state     <= S_OFF;
                            cnt       <= '0;
                            led_on    <= 1'b0;
                            led_color <= 2'd0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_OFF: begin
                    if (!hold) begin
                        if (cnt == OFF_LAST) begin
                            cnt <= '0;
                            if (idx == last_idx) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_ON;
                                idx       <= next_idx;
                                led_on    <= 1'b1;
                                led_color <= mem[next_idx];
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
